// File: rtl/mem_stage.sv
// Memory pipeline stage: registers the execute-to-memory bus, holds the SRAM read word
// across stalls, extracts/extends load data and drives the writeback and bypass buses.
module mem_stage #(
  parameter int STALL_W  = 6,
  parameter int EX_MEM_W = 147,
  parameter int MEM_WB_W = 136
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic [STALL_W-1:0]  stall,
  input  logic [EX_MEM_W-1:0] ex_to_mem_bus,
  input  logic [31:0]         data_sram_rdata,
  output logic [MEM_WB_W-1:0] mem_to_wb_bus,
  output logic [37:0]         mem_fwd_bus,
  output logic [65:0]         mem_hilo_fwd,
  output logic                load_misalign
);

  localparam int STALL_SELF = 3;
  localparam int STALL_WB   = 4;

  function automatic logic is_load_f(input logic [EX_MEM_W-1:0] bus);
    return bus[43] & (bus[42:39] == 4'b0000) & bus[38];
  endfunction

  logic [EX_MEM_W-1:0] stage_q, stage_d;
  logic                first_cycle_q, first_cycle_d;
  logic [31:0]         rdata_hold_q, rdata_hold_d;

  logic unused_stall;
  assign unused_stall = ^{stall[STALL_W-1:STALL_WB+1], stall[STALL_SELF-1:0]};

  // Next-state for the stage register, first-cycle flag and read-word hold register.
  always_comb begin
    stage_d       = stage_q;
    first_cycle_d = 1'b0;
    rdata_hold_d  = rdata_hold_q;
    if (flush) begin
      stage_d = '0;
    end else if (stall[STALL_SELF] && !stall[STALL_WB]) begin
      stage_d = '0;
    end else if (!stall[STALL_SELF]) begin
      stage_d       = ex_to_mem_bus;
      first_cycle_d = is_load_f(ex_to_mem_bus);
    end else begin
      stage_d = stage_q;
    end
    if (first_cycle_q) begin
      rdata_hold_d = data_sram_rdata;
    end else begin
      rdata_hold_d = rdata_hold_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stage_q       <= '0;
      first_cycle_q <= 1'b0;
      rdata_hold_q  <= 32'h0000_0000;
    end else begin
      stage_q       <= stage_d;
      first_cycle_q <= first_cycle_d;
      rdata_hold_q  <= rdata_hold_d;
    end
  end

  logic [65:0] hilo_s;
  logic [4:0]  mem_op_s;
  logic [31:0] pc_s;
  logic        sel_rf_res_s;
  logic        rf_we_s;
  logic [4:0]  rf_waddr_s;
  logic [31:0] ex_result_s;
  logic [1:0]  addr_lo_s;
  logic        is_load_s;
  logic [31:0] rdata_eff_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] load_data_s;
  logic [31:0] rf_wdata_s;

  assign hilo_s       = stage_q[146:81];
  assign mem_op_s     = stage_q[80:76];
  assign pc_s         = stage_q[75:44];
  assign sel_rf_res_s = stage_q[38];
  assign rf_we_s      = stage_q[37];
  assign rf_waddr_s   = stage_q[36:32];
  assign ex_result_s  = stage_q[31:0];
  assign addr_lo_s    = ex_result_s[1:0];
  assign is_load_s    = is_load_f(stage_q);

  // Load data selection: pick the lane, then sign- or zero-extend by mem_op.
  always_comb begin
    rdata_eff_s = first_cycle_q ? data_sram_rdata : rdata_hold_q;
    case (addr_lo_s)
      2'd0:    byte_s = rdata_eff_s[7:0];
      2'd1:    byte_s = rdata_eff_s[15:8];
      2'd2:    byte_s = rdata_eff_s[23:16];
      2'd3:    byte_s = rdata_eff_s[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo_s[1]) begin
      half_s = rdata_eff_s[31:16];
    end else begin
      half_s = rdata_eff_s[15:0];
    end
    if (mem_op_s[4]) begin
      load_data_s = {{24{byte_s[7]}}, byte_s};
    end else if (mem_op_s[3]) begin
      load_data_s = {24'h000000, byte_s};
    end else if (mem_op_s[2]) begin
      load_data_s = {{16{half_s[15]}}, half_s};
    end else if (mem_op_s[1]) begin
      load_data_s = {16'h0000, half_s};
    end else begin
      load_data_s = rdata_eff_s;
    end
    if (sel_rf_res_s) begin
      rf_wdata_s = load_data_s;
    end else begin
      rf_wdata_s = ex_result_s;
    end
  end

  assign load_misalign = is_load_s &
                         (((mem_op_s[2] | mem_op_s[1]) & addr_lo_s[0]) |
                          (mem_op_s[0] & (addr_lo_s != 2'b00)));

  assign mem_to_wb_bus = {hilo_s, pc_s, rf_we_s, rf_waddr_s, rf_wdata_s};
  assign mem_fwd_bus   = {rf_we_s, rf_waddr_s, rf_wdata_s};
  assign mem_hilo_fwd  = hilo_s;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Registers the execute-to-memory bus under stall/flush control.
- Captures the data-SRAM read word one cycle after the request and holds it across stalls.
- Performs load byte/halfword extraction and sign/zero extension, then produces the memory-to-writeback bus plus a forwarding bus back to decode.

Parameters:
- STALL_W, 6, width of the stall vector; bit 3 = this stage, bit 4 = writeback.
- EX_MEM_W, 147, width of the incoming execute-to-memory bus.
- MEM_WB_W, 136, width of the outgoing memory-to-writeback bus.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  clears the stage register.
- stall  in  STALL_W  pipeline stall vector (1 = Stop).
- ex_to_mem_bus  in  147  fields by bit range:
  - [146:81] hilo_bus {hi_we, lo_we, hi[31:0], lo[31:0]}
  - [80:76] mem_op
  - [75:44] pc
  - [43] data_ram_en
  - [42:39] data_ram_wen
  - [38] sel_rf_res
  - [37] rf_we
  - [36:32] rf_waddr
  - [31:0] ex_result (also the byte address)
- data_sram_rdata  in  32  SRAM read word; valid only in the cycle after the request was issued.
- mem_to_wb_bus  out  136  fields by bit range:
  - [135:70] hilo_bus
  - [69:38] pc
  - [37] rf_we
  - [36:32] rf_waddr
  - [31:0] rf_wdata
- mem_fwd_bus  out  38  {rf_we, rf_waddr, rf_wdata} to decode bypass.
- mem_hilo_fwd  out  66  hilo_bus copy to decode for mfhi/mflo bypass.
- load_misalign  out  1  misaligned halfword/word load flag in the current cycle.

Behaviour:
- Reset:
  - Asynchronous on resetn low: stage register, hold register and first_cycle flag all clear to 0.
  - All outputs therefore read 0: rf_we = 0, hi_we = lo_we = 0, load_misalign = 0.
- Stage register update, priority order each rising edge:
  1. flush -> clear to 0.
  2. stall[3]=Stop and stall[4]=NoStop -> clear to 0 (bubble).
  3. stall[3]=NoStop -> load ex_to_mem_bus.
  4. Otherwise hold.
- mem_op one-hot: bit4 lb, bit3 lbu, bit2 lh, bit1 lhu, bit0 lw.
- is_load = data_ram_en & (data_ram_wen == 0) & (sel_rf_res == 1).
- first_cycle flag:
  - Set to 1 on any edge where the register loads an entry with is_load = 1; cleared to 0 on every other edge.
  - Flush or bubble clears it.
- Hold register (rdata_hold):
  - Captures data_sram_rdata on every edge where first_cycle = 1; otherwise keeps its value.
  - Effective read word: rdata_eff = first_cycle ? data_sram_rdata : rdata_hold.
  - Loads stalled any number of cycles in this stage therefore use the word returned in their first cycle.
- Load extraction, a = ex_result[1:0]:
  - lb/lbu: byte a of rdata_eff (byte 0 = bits 7:0), sign- or zero-extended to 32.
  - lh/lhu: a[1]=0 -> bits 15:0; a[1]=1 -> bits 31:16; sign- or zero-extended.
  - lw: rdata_eff unchanged.
- rf_wdata = sel_rf_res ? extracted load data : ex_result.
- Stores (data_ram_wen != 0) pass ex_result through. Their rf_we is whatever the execute stage encoded (0 for stores).
- load_misalign:
  - Asserts when (lh|lhu) & a[0], or lw & (a != 0), while is_load = 1.
  - Data is still extracted as above; the flag is informational for the exception unit.
- All outputs are combinational from the stage register, first_cycle, rdata_hold and data_sram_rdata. There is no added latency beyond the single stage register.
- mem_fwd_bus and mem_hilo_fwd equal the corresponding mem_to_wb_bus fields in the same cycle.
- Simultaneous events:
  - flush overrides stall.
  - Reset overrides everything, including mid-stall. A load held at reset is discarded and is not replayed.

Test Plan:
- Reset: hold resetn=0 with random bus -> all outputs 0; release and load lw at addr 0x100 with rdata 0x8899AABB -> next-cycle rf_wdata=0x8899AABB, rf_we=1.
- Byte extraction: rdata 0x80FF7F01, lb at a=0/1/2/3 -> 0x00000001/0x0000007F/0xFFFFFFFF/0xFFFFFF80; lbu at a=3 -> 0x00000080; lh a=2 -> 0xFFFF80FF; lhu a=0 -> 0x00007F01.
- Stall hold: lw enters, rdata 0x12345678 in first cycle, then stall[4:3]=2'b11 for 3 cycles while rdata changes to 0xDEADBEEF -> rf_wdata remains 0x12345678 throughout.
- Bubble/flush: stall[3]=Stop, stall[4]=NoStop -> next cycle rf_we=0, hi_we=lo_we=0. flush asserted together with stall[3]=NoStop -> register cleared, not loaded.
- Non-load passthrough: ALU op ex_result=0x0000002A, rf_waddr=5, hilo_bus with hi_we=1, hi=0x11 -> mem_to_wb_bus and mem_fwd_bus carry 0x2A to r5, and mem_hilo_fwd carries hi_we=1, hi=0x11.
- Misalign: lh at 0x1001 -> load_misalign=1; lw at 0x1002 -> load_misalign=1; lw at 0x1004 -> load_misalign=0.
